booth_prod_accum: RTL and testbench

//  Sequential signed accumulator directly downstream of the 4x4 Booth multiplier.

---
 rtl/booth_prod_accum.sv | 146 ++++++++++++++
 tb/tb_booth_prod_accum.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_prod_accum.sv
// booth_prod_accum
// Signed frame accumulator placed after the 4x4 Booth multiplier. Products
// arrive one per cycle on a valid/ready handshake and are summed with
// saturation until in_last or the MAX_TERMS limit closes the frame. The
// closed-frame result is held on a registered valid/ready output until taken.
module booth_prod_accum #(
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_forced
);

    // Two-state frame controller: collecting products, or holding a result.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Saturation limits of the signed accumulator.
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    // Count value at which a frame is force-closed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TERMS);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_sat;
    logic               r_out_forced;

    logic [ACC_W:0]     w_sum_ext;
    logic               w_ovf_pos;
    logic               w_ovf_neg;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_sat_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_hit_max;
    logic               w_close;

    // Next accumulator value: one guard bit catches overflow in either
    // direction, then the result is clamped to the representable range.
    always_comb begin
        w_sum_ext  = {r_acc[ACC_W-1], r_acc}
                   + {{(ACC_W-7){in_product[7]}}, in_product};
        w_ovf_pos  = ~w_sum_ext[ACC_W] &  w_sum_ext[ACC_W-1];
        w_ovf_neg  =  w_sum_ext[ACC_W] & ~w_sum_ext[ACC_W-1];
        if (w_ovf_pos) begin
            w_acc_next = ACC_MAX;
        end else if (w_ovf_neg) begin
            w_acc_next = ACC_MIN;
        end else begin
            w_acc_next = w_sum_ext[ACC_W-1:0];
        end
        w_sat_next = r_sat | w_ovf_pos | w_ovf_neg;
        w_cnt_next = r_cnt + CNT_W'(1);
        w_hit_max  = (w_cnt_next == CNT_LAST);
        w_close    = in_last | w_hit_max;
    end

    // Frame controller with registered handshake outputs; clr overrides
    // both the input beat and the downstream handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ACCUM;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_count  <= '0;
            r_out_sat    <= 1'b0;
            r_out_forced <= 1'b0;
        end else if (clr) begin
            // Result data is left in place; only its valid is withdrawn.
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (w_close) begin
                            r_out_sum    <= w_acc_next;
                            r_out_count  <= w_cnt_next;
                            r_out_sat    <= w_sat_next;
                            r_out_forced <= w_hit_max & ~in_last;
                            r_acc        <= '0;
                            r_cnt        <= '0;
                            r_sat        <= 1'b0;
                            r_state      <= ST_HOLD;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_next;
                            r_sat <= w_sat_next;
                        end
                    end
                end
                ST_HOLD: begin
                    // No bypass: input reopens only the cycle after handoff.
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_sum    = r_out_sum;
    assign out_count  = r_out_count;
    assign out_sat    = r_out_sat;
    assign out_forced = r_out_forced;

endmodule

// File: tb/tb_booth_prod_accum.sv
// Testbench for booth_prod_accum. Three instances share one input bundle:
// default sizing, a narrow 10-bit accumulator, and a 4-term frame limit.
// Each section resets all of them and checks only the instance it targets.
module tb_booth_prod_accum;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_valid, in_last, out_ready;
    logic [7:0] in_product;

    logic        rdy0, ov0, sat0, frc0;
    logic [15:0] sum0;
    logic [7:0]  cnt0;
    logic        rdy1, ov1, sat1, frc1;
    logic [9:0]  sum1;
    logic [7:0]  cnt1;
    logic        rdy2, ov2, sat2, frc2;
    logic [15:0] sum2;
    logic [2:0]  cnt2;

    always #5 clk = ~clk;

    booth_prod_accum #(.ACC_W(16), .MAX_TERMS(255), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_product(in_product), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
        .out_sum(sum0), .out_count(cnt0), .out_sat(sat0), .out_forced(frc0));

    booth_prod_accum #(.ACC_W(10), .MAX_TERMS(255), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_product(in_product), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .out_sum(sum1), .out_count(cnt1), .out_sat(sat1), .out_forced(frc1));

    booth_prod_accum #(.ACC_W(16), .MAX_TERMS(4), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .in_product(in_product), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
        .out_sum(sum2), .out_count(cnt2), .out_sat(sat2), .out_forced(frc2));

    int n_pass  = 0;
    int n_total = 0;
    int cur_d   = 0;
    string sect = "";

    // Sampled outputs of the instance under test.
    int a_rdy, a_ov, a_sum, a_cnt, a_sat, a_frc;

    // Reference model state: frame in progress and last published result.
    int m_acc, m_cnt, m_sat, m_hold;
    int e_sum, e_cnt, e_sat, e_frc;

    function automatic int accw_of(int d);
        return (d == 1) ? 10 : 16;
    endfunction

    function automatic int maxt_of(int d);
        return (d == 2) ? 4 : 255;
    endfunction

    task automatic sample(input int d);
        case (d)
            0: begin
                a_rdy = int'(rdy0); a_ov = int'(ov0); a_sum = int'($signed(sum0));
                a_cnt = int'(cnt0); a_sat = int'(sat0); a_frc = int'(frc0);
            end
            1: begin
                a_rdy = int'(rdy1); a_ov = int'(ov1); a_sum = int'($signed(sum1));
                a_cnt = int'(cnt1); a_sat = int'(sat1); a_frc = int'(frc1);
            end
            default: begin
                a_rdy = int'(rdy2); a_ov = int'(ov2); a_sum = int'($signed(sum2));
                a_cnt = int'(cnt2); a_sat = int'(sat2); a_frc = int'(frc2);
            end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d", name, cur_d, act, exp);
    endtask

    function automatic void model_reset();
        m_acc = 0; m_cnt = 0; m_sat = 0; m_hold = 0;
        e_sum = 0; e_cnt = 0; e_sat = 0; e_frc = 0;
    endfunction

    // Transaction-level model of one clock edge.
    function automatic void model_step(int c, int v, int p, int l, int r);
        int s, hi, lo;
        hi = (1 << (accw_of(cur_d) - 1)) - 1;
        lo = -hi - 1;
        if (c != 0) begin
            m_hold = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
        end else if (m_hold == 0) begin
            if (v != 0) begin
                s = m_acc + ((p > 127) ? p - 256 : p);
                if (s > hi) begin s = hi; m_sat = 1; end
                if (s < lo) begin s = lo; m_sat = 1; end
                m_cnt++;
                if (l != 0 || m_cnt == maxt_of(cur_d)) begin
                    e_sum = s; e_cnt = m_cnt; e_sat = m_sat;
                    e_frc = (m_cnt == maxt_of(cur_d) && l == 0) ? 1 : 0;
                    $display("frame dut%0d %s: sum=%0d count=%0d sat=%0d forced=%0d",
                             cur_d, sect, e_sum, e_cnt, e_sat, e_frc);
                    m_hold = 1; m_acc = 0; m_cnt = 0; m_sat = 0;
                end else begin
                    m_acc = s;
                end
            end
        end else if (r != 0) begin
            m_hold = 0;
        end
    endfunction

    task automatic chk_model();
        bit ok;
        sample(cur_d);
        ok = (a_rdy == 1 - m_hold) && (a_ov == m_hold) && (a_sum == e_sum) &&
             (a_cnt == e_cnt) && (a_sat == e_sat) && (a_frc == e_frc);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s dut%0d: rdy=%0d ov=%0d sum=%0d cnt=%0d sat=%0d frc=%0d, expected rdy=%0d ov=%0d sum=%0d cnt=%0d sat=%0d frc=%0d",
                      sect, cur_d, a_rdy, a_ov, a_sum, a_cnt, a_sat, a_frc,
                      1 - m_hold, m_hold, e_sum, e_cnt, e_sat, e_frc);
    endtask

    // Drive one cycle of inputs at the falling edge, check at the next one.
    task automatic cycle(input int c, input int v, input int p, input int l, input int r);
        clr = (c != 0); in_valid = (v != 0); in_product = 8'(p);
        in_last = (l != 0); out_ready = (r != 0);
        model_step(c, v, p, l, r);
        @(negedge clk);
        chk_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_product = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Assert rst_n between clock edges and check outputs clear without a clock.
    task automatic async_rst(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        sample(cur_d);
        chk({name, " ready"}, a_rdy, 1);
        chk({name, " valid"}, a_ov, 0);
        chk({name, " sum"},   a_sum, 0);
        chk({name, " count"}, a_cnt, 0);
        chk({name, " sat"},   a_sat + a_frc, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int v, p, l, r;
        int e_rdy, e_ov, e_sum, e_cnt, e_sat, e_frc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v  p      l  r   rdy ov  sum   cnt sat frc
        tbl[0] = '{1, 'h31, 0, 0,  1, 0,    0,   0, 0, 0};
        tbl[1] = '{1, 'hC8, 0, 0,  1, 0,    0,   0, 0, 0};
        tbl[2] = '{1, 'h0C, 1, 0,  0, 1,    5,   3, 0, 0};
        tbl[3] = '{1, 'h7F, 1, 0,  0, 1,    5,   3, 0, 0};
        tbl[4] = '{0, 'h00, 0, 1,  1, 0,    5,   3, 0, 0};
        tbl[5] = '{1, 'h80, 1, 0,  0, 1, -128,   1, 0, 0};
        tbl[6] = '{0, 'h00, 0, 1,  1, 0, -128,   1, 0, 0};
        tbl[7] = '{1, 'h7F, 0, 0,  1, 0, -128,   1, 0, 0};
        tbl[8] = '{1, 'h7F, 0, 0,  1, 0, -128,   1, 0, 0};
        tbl[9] = '{1, 'h01, 1, 0,  0, 1,  255,   3, 0, 0};

        // Reset values.
        cur_d = 0; sect = "reset";
        do_reset();
        sample(0);
        chk("reset ready", a_rdy, 1);
        chk("reset valid", a_ov, 0);
        chk("reset sum", a_sum, 0);
        chk("reset count", a_cnt, 0);

        // Basic frame, latency, held beat, single-term frame.
        sect = "table";
        for (int i = 0; i < 10; i++) begin
            clr = 1'b0; in_valid = (tbl[i].v != 0); in_product = 8'(tbl[i].p);
            in_last = (tbl[i].l != 0); out_ready = (tbl[i].r != 0);
            @(negedge clk);
            sample(0);
            $display("vec %0d: rdy=%0d ov=%0d sum=%0d cnt=%0d sat=%0d frc=%0d",
                     i, a_rdy, a_ov, a_sum, a_cnt, a_sat, a_frc);
            n_total++;
            if (a_rdy == tbl[i].e_rdy && a_ov == tbl[i].e_ov && a_sum == tbl[i].e_sum &&
                a_cnt == tbl[i].e_cnt && a_sat == tbl[i].e_sat && a_frc == tbl[i].e_frc)
                n_pass++;
            else
                $display("FAIL vec%0d: rdy=%0d ov=%0d sum=%0d cnt=%0d sat=%0d frc=%0d, expected rdy=%0d ov=%0d sum=%0d cnt=%0d sat=%0d frc=%0d",
                         i, a_rdy, a_ov, a_sum, a_cnt, a_sat, a_frc, tbl[i].e_rdy,
                         tbl[i].e_ov, tbl[i].e_sum, tbl[i].e_cnt, tbl[i].e_sat, tbl[i].e_frc);
        end

        // Saturation on the 10-bit accumulator.
        cur_d = 1; sect = "sat";
        do_reset();
        for (int i = 0; i < 8; i++) cycle(0, 1, 'h40, int'(i == 7), 0);
        sample(1);
        chk("sat pos sum", a_sum, 511);
        chk("sat pos flag", a_sat, 1);
        chk("sat pos count", a_cnt, 8);
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(0, 1, 'hC0, int'(i == 7), 0);
        sample(1);
        chk("exact min sum", a_sum, -512);
        chk("exact min flag", a_sat, 0);
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(0, 1, 'hC0, int'(i == 8), 0);
        sample(1);
        chk("sat neg sum", a_sum, -512);
        chk("sat neg flag", a_sat, 1);

        // Forced close at MAX_TERMS=4; the fifth beat waits for handoff.
        cur_d = 2; sect = "forced";
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);
        sample(2);
        chk("forced sum", a_sum, 4);
        chk("forced count", a_cnt, 4);
        chk("forced flag", a_frc, 1);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 1);
        sample(2);
        chk("forced reopen ready", a_rdy, 1);
        cycle(0, 1, 1, 1, 0);
        sample(2);
        chk("new frame count", a_cnt, 1);
        chk("new frame forced", a_frc, 0);

        // Back-pressure: result held for 10 cycles.
        cur_d = 0; sect = "bp";
        do_reset();
        cycle(0, 1, 'h7F, 0, 0);
        cycle(0, 1, 'h05, 1, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, int'($urandom_range(255, 0)), int'($urandom_range(1, 0)), 0);
        sample(0);
        chk("bp sum held", a_sum, 132);
        chk("bp ready low", a_rdy, 0);
        cycle(0, 0, 0, 0, 1);
        sample(0);
        chk("bp ready after handoff", a_rdy, 1);
        chk("bp sum retained", a_sum, 132);

        // Clear mid-frame and during HOLD.
        sect = "clr";
        do_reset();
        cycle(0, 1, 'h10, 0, 0);
        cycle(0, 1, 'h10, 0, 0);
        cycle(1, 1, 'h55, 1, 0);
        sample(0);
        chk("clr beat discarded", a_ov, 0);
        cycle(0, 1, 'h22, 1, 0);
        sample(0);
        chk("clr acc cleared", a_sum, 34);
        cycle(1, 0, 0, 0, 0);
        sample(0);
        chk("clr hold valid", a_ov, 0);
        chk("clr hold data kept", a_sum, 34);
        cycle(0, 1, 'h03, 1, 0);
        sample(0);
        chk("clr next sum", a_sum, 3);
        chk("clr next count", a_cnt, 1);

        // Asynchronous reset mid-frame and in HOLD.
        sect = "arst";
        do_reset();
        cycle(0, 1, 'h20, 0, 0);
        cycle(0, 1, 'h20, 0, 0);
        async_rst("arst frame");
        cycle(0, 1, 'h07, 1, 0);
        sample(0);
        chk("arst frame restart", a_sum, 7);
        async_rst("arst hold");
        cycle(0, 1, 'hFE, 1, 0);
        sample(0);
        chk("arst hold restart", a_sum, -2);

        // Randomised traffic on every instance against the model.
        for (int d = 0; d < 3; d++) begin
            cur_d = d; sect = "rand";
            do_reset();
            for (int i = 0; i < 500; i++)
                cycle(int'($urandom_range(31, 0) == 0), int'($urandom_range(3, 0) != 0),
                      int'($urandom_range(255, 0)),
                      int'($urandom_range((d == 2) ? 7 : 5, 0) == 0),
                      int'($urandom_range(2, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
